i2c_slave_rx: RTL and testbench
===============================

Name: i2c_slave_rx

Overview:
- I2C slave receive controller directly downstream of the SCL edge detector. Consumes its rising/falling-edge strobes plus synchronized SCL/SDA levels.
- Detects START/STOP conditions and shifts in the address byte. On an address match with write, ACKs and shifts in data bytes, presenting each byte to the RX FIFO with a one-cycle valid strobe.
- Read transfers are not handled here; the sibling transmit block owns them, using rw_mode and addr_match.

Parameters:
- SLAVE_ADDR, 7'h1E, 7-bit bus address this slave answers to.
- DATA_WIDTH, 8, byte width; fixed at 8 by the I2C protocol and not to be overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- scl_in  in  1  synchronized SCL level.
- sda_in  in  1  synchronized SDA level.
- rising_edge_found  in  1  one-cycle strobe, SCL rose.
- falling_edge_found  in  1  one-cycle strobe, SCL fell.
- rx_fifo_full  in  1  downstream FIFO cannot accept a byte.
- rx_data  out  8  last received data byte, MSB first on the wire.
- rx_valid  out  1  one-cycle strobe, rx_data newly loaded.
- addr_match  out  1  high from address-byte completion until STOP/START if the address equals SLAVE_ADDR.
- rw_mode  out  1  R/W bit of the last address byte (1 = read).
- sda_out  out  1  open-drain drive; 0 = pull SDA low, 1 = release.
- start_found  out  1  one-cycle strobe on START or repeated START.
- stop_found  out  1  one-cycle strobe on STOP.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, addr_match=0, rw_mode=0, sda_out=1, start_found=0, stop_found=0, busy=0, state=IDLE, bit_cnt=0, sda_prev=1.
- sda_prev is sda_in registered each clk.
- START = scl_in & sda_prev & ~sda_in. STOP = scl_in & ~sda_prev & sda_in. Both are registered into 1-cycle strobes.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- START from any state: go to ADDR; clear bit_cnt, shift register and addr_match; sda_out=1.
- STOP from any state: go to IDLE; sda_out=1; addr_match=0.
- START/STOP take priority over a coincident edge strobe in the same cycle.
- ADDR: on each rising_edge_found, shift in sda_in MSB first and increment bit_cnt.
  - After the 8th bit, latch rw_mode = bit0 and addr_match = (bits[7:1]==SLAVE_ADDR), then wait for falling_edge_found.
  - At that falling edge: if match and write, go to ADDR_ACK with sda_out=0. Otherwise (mismatch or read) go to IGNORE with sda_out=1.
- ADDR_ACK: on the next falling_edge_found, sda_out=1, clear bit_cnt, go to DATA.
- DATA: shift as in ADDR. The cycle after the 8th rising edge:
  - if rx_fifo_full=0: load rx_data and pulse rx_valid for 1 clk;
  - if full: the byte is dropped.
  - At the next falling_edge_found, go to DATA_ACK with sda_out = rx_fifo_full value captured at the 8th bit (0 = ACK, 1 = NACK).
- DATA_ACK: on the next falling_edge_found, sda_out=1, clear bit_cnt, return to DATA. After a NACK, go to IGNORE instead.
- IGNORE: hold sda_out=1; leave only on START or STOP.
- Latency: rx_valid is asserted exactly 1 clk after the rising_edge_found strobe of bit 8.
- The ACK low level spans exactly one SCL period, falling edge to falling edge.
- rst asserted mid-byte: immediate return to reset values; sda_out is released asynchronously.

Decomposition:
- Shared package i2c_pkg holds:
  - state enum i2c_rx_state_t (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE);
  - I2C_BYTE_BITS = 8;
  - I2C_ACK = 1'b0, I2C_NACK = 1'b1.
- One natural sub-module: i2c_bus_cond, containing the sda_prev register and the START/STOP detect strobes.
- The FSM and shift register stay in i2c_slave_rx.

Test Plan:
- START, then address byte 0x3C (addr 0x1E, W) -> sda_out=0 for the 9th SCL period, addr_match=1, rw_mode=0, start_found pulsed once.
- Continue with data 0xA5 -> rx_data=0xA5, rx_valid high exactly 1 clk after the 8th rising edge, ACK on the 9th clock.
- Address 0x80 (addr 0x40) -> sda_out stays 1, addr_match=0, state IGNORE, no rx_valid through the following 0xFF byte.
- Address 0x3C ACKed; rx_fifo_full=1 during data 0x5A -> no rx_valid, sda_out=1 on the 9th clock (NACK), state IGNORE until STOP.
- Repeated START after 3 data bits, then 0x3C and 0x11 -> bit_cnt restarts, second address ACKed, rx_data=0x11.
- rst pulsed during the ACK low of the address byte -> sda_out=1 within the same cycle, all outputs at reset values, busy=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receive path.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_rx_state_t;

    localparam int   I2C_BYTE_BITS = 8;
    localparam logic I2C_ACK       = 1'b0;
    localparam logic I2C_NACK      = 1'b1;

endpackage

// File: rtl/i2c_bus_cond.sv
// START/STOP bus-condition detector: tracks the previous SDA level and
// flags SDA transitions that happen while SCL is high.
module i2c_bus_cond
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic start_found,
    output logic stop_found
);

    logic sda_prev_d, sda_prev_q;
    logic start_d, start_q;
    logic stop_d, stop_q;

    // Next-state: SDA falling with SCL high is START, SDA rising with SCL high is STOP.
    always_comb begin
        sda_prev_d = sda_in;
        start_d    = scl_in & sda_prev_q & ~sda_in;
        stop_d     = scl_in & ~sda_prev_q & sda_in;
    end

    // Register the previous SDA level and the one-cycle condition strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_prev_q <= 1'b1;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            sda_prev_q <= sda_prev_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign start_found = start_q;
    assign stop_found  = stop_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C slave receive controller: address decode, write-data shift-in,
// ACK/NACK generation and byte hand-off to the RX FIFO.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h1E,
    parameter int         DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    input  logic                  rising_edge_found,
    input  logic                  falling_edge_found,
    input  logic                  rx_fifo_full,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  addr_match,
    output logic                  rw_mode,
    output logic                  sda_out,
    output logic                  start_found,
    output logic                  stop_found,
    output logic                  busy
);

    localparam logic [3:0] BYTE_CNT = 4'(I2C_BYTE_BITS);

    logic start_det, stop_det;

    i2c_bus_cond u_bus_cond (
        .clk         (clk),
        .rst         (rst),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .start_found (start_det),
        .stop_found  (stop_det)
    );

    i2c_rx_state_t         state_d, state_q;
    logic [3:0]            bit_cnt_d, bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_d, shift_q;
    logic [DATA_WIDTH-1:0] rx_data_d, rx_data_q;
    logic                  rx_valid_d, rx_valid_q;
    logic                  addr_match_d, addr_match_q;
    logic                  rw_mode_d, rw_mode_q;
    logic                  sda_out_d, sda_out_q;
    logic                  full_d, full_q;
    logic                  busy_d, busy_q;

    // Next-state logic; bus conditions override any edge strobe in the same cycle.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        addr_match_d = addr_match_q;
        rw_mode_d    = rw_mode_q;
        sda_out_d    = sda_out_q;
        full_d       = full_q;

        if (start_det) begin
            state_d      = ADDR;
            bit_cnt_d    = '0;
            shift_d      = '0;
            addr_match_d = 1'b0;
            sda_out_d    = 1'b1;
        end else if (stop_det) begin
            state_d      = IDLE;
            addr_match_d = 1'b0;
            sda_out_d    = 1'b1;
        end else begin
            case (state_q)
                ADDR: begin
                    if (bit_cnt_q != BYTE_CNT) begin
                        if (rising_edge_found) begin
                            shift_d   = {shift_q[DATA_WIDTH-2:0], sda_in};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q == BYTE_CNT - 4'd1) begin
                                // shift_q still holds the seven address bits here
                                rw_mode_d    = sda_in;
                                addr_match_d = (shift_q[6:0] == SLAVE_ADDR);
                            end
                        end
                    end else if (falling_edge_found) begin
                        if (addr_match_q && !rw_mode_q) begin
                            state_d   = ADDR_ACK;
                            sda_out_d = I2C_ACK;
                        end else begin
                            state_d   = IGNORE;
                            sda_out_d = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (falling_edge_found) begin
                        sda_out_d = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    if (bit_cnt_q != BYTE_CNT) begin
                        if (rising_edge_found) begin
                            shift_d   = {shift_q[DATA_WIDTH-2:0], sda_in};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q == BYTE_CNT - 4'd1) begin
                                // FIFO state at the last bit decides both hand-off and ACK
                                full_d = rx_fifo_full;
                                if (!rx_fifo_full) begin
                                    rx_data_d  = {shift_q[DATA_WIDTH-2:0], sda_in};
                                    rx_valid_d = 1'b1;
                                end
                            end
                        end
                    end else if (falling_edge_found) begin
                        state_d   = DATA_ACK;
                        sda_out_d = full_q ? I2C_NACK : I2C_ACK;
                    end
                end
                DATA_ACK: begin
                    if (falling_edge_found) begin
                        sda_out_d = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = full_q ? IGNORE : DATA;
                    end
                end
                IGNORE: begin
                    sda_out_d = 1'b1;
                end
                default: begin
                    sda_out_d = 1'b1;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // FSM and datapath registers; reset releases SDA immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            rw_mode_q    <= 1'b0;
            sda_out_q    <= 1'b1;
            full_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            rw_mode_q    <= rw_mode_d;
            sda_out_q    <= sda_out_d;
            full_q       <= full_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign addr_match  = addr_match_q;
    assign rw_mode     = rw_mode_q;
    assign sda_out     = sda_out_q;
    assign start_found = start_det;
    assign stop_found  = stop_det;
    assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-level I2C master model, wired-AND SDA bus,
// scoreboard of expected FIFO bytes with their required arrival cycle.
module tb_i2c_slave_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       rise = 1'b0;
    logic       fall = 1'b0;
    logic       full = 1'b0;
    logic       sda_in;
    logic [7:0] rx_data;
    logic       rx_valid, addr_match, rw_mode, sda_out;
    logic       start_found, stop_found, busy;

    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_start = 0;
    int          n_stop = 0;
    int          n_valid = 0;

    assign sda_in = sda_m & sda_out;

    i2c_slave_rx #(.SLAVE_ADDR(7'h1E), .DATA_WIDTH(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .scl_in             (scl),
        .sda_in             (sda_in),
        .rising_edge_found  (rise),
        .falling_edge_found (fall),
        .rx_fifo_full       (full),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .addr_match         (addr_match),
        .rw_mode            (rw_mode),
        .sda_out            (sda_out),
        .start_found        (start_found),
        .stop_found         (stop_found),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every rx_valid pulse must match the next expected byte and cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    check_eq("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("rx_data_sb", {24'd0, rx_data}, {24'd0, e.data});
                    check_eq("rx_valid_cycle", cyc, e.cyc);
                end
            end
            if (start_found) n_start++;
            if (stop_found)  n_stop++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // One SCL period per bit; entry and exit at a negedge with SCL low.
    task automatic send_bit(input logic b, input bit push, input logic [7:0] d);
        sda_m = b;
        repeat (2) @(negedge clk);
        scl = 1'b1; rise = 1'b1;
        if (push) exp_q.push_back('{data: d, cyc: cyc + 32'd1});
        @(negedge clk);
        rise = 1'b0;
        repeat (3) @(negedge clk);
        scl = 1'b0; fall = 1'b1;
        @(negedge clk);
        fall = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit push);
        for (int i = 7; i >= 0; i--) send_bit(d[i], push && (i == 0), d);
    endtask

    task automatic ack_bit(input logic exp, input string tag);
        sda_m = 1'b1;
        check_eq({tag, "_lo"}, {31'd0, sda_out}, {31'd0, exp});
        repeat (2) @(negedge clk);
        scl = 1'b1; rise = 1'b1;
        @(negedge clk);
        rise = 1'b0;
        repeat (3) @(negedge clk);
        check_eq({tag, "_hi"}, {31'd0, sda_out}, {31'd0, exp});
        scl = 1'b0; fall = 1'b1;
        @(negedge clk);
        fall = 1'b0;
        check_eq({tag, "_rel"}, {31'd0, sda_out}, 32'd1);
    endtask

    task automatic do_start();
        sda_m = 1'b1;
        repeat (2) @(negedge clk);
        if (!scl) begin
            scl = 1'b1; rise = 1'b1;
            @(negedge clk);
            rise = 1'b0;
            repeat (2) @(negedge clk);
        end
        sda_m = 1'b0;
        repeat (3) @(negedge clk);
        scl = 1'b0; fall = 1'b1;
        @(negedge clk);
        fall = 1'b0;
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        repeat (2) @(negedge clk);
        scl = 1'b1; rise = 1'b1;
        @(negedge clk);
        rise = 1'b0;
        repeat (2) @(negedge clk);
        sda_m = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_rx_data"},    {24'd0, rx_data},     32'd0);
        check_eq({tag, "_rx_valid"},   {31'd0, rx_valid},    32'd0);
        check_eq({tag, "_addr_match"}, {31'd0, addr_match},  32'd0);
        check_eq({tag, "_rw_mode"},    {31'd0, rw_mode},     32'd0);
        check_eq({tag, "_sda_out"},    {31'd0, sda_out},     32'd1);
        check_eq({tag, "_start"},      {31'd0, start_found}, 32'd0);
        check_eq({tag, "_stop"},       {31'd0, stop_found},  32'd0);
        check_eq({tag, "_busy"},       {31'd0, busy},        32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Matching write address, then one data byte
        do_start();
        send_byte(8'h3C, 1'b0);
        check_eq("addr_match_hit", {31'd0, addr_match}, 32'd1);
        check_eq("rw_mode_write",  {31'd0, rw_mode},    32'd0);
        check_eq("start_once",     n_start,             32'd1);
        ack_bit(1'b0, "addr_ack");
        check_eq("busy_data", {31'd0, busy}, 32'd1);
        send_byte(8'hA5, 1'b1);
        ack_bit(1'b0, "data_ack");
        check_eq("rx_data_a5", {24'd0, rx_data}, 32'h0000_00A5);
        do_stop();
        check_eq("stop_once",      n_stop,              32'd1);
        check_eq("busy_idle",      {31'd0, busy},       32'd0);
        check_eq("addr_match_clr", {31'd0, addr_match}, 32'd0);

        // Foreign address: no ACK, following byte ignored
        do_start();
        send_byte(8'h80, 1'b0);
        check_eq("addr_match_miss", {31'd0, addr_match}, 32'd0);
        ack_bit(1'b1, "addr_nack");
        send_byte(8'hFF, 1'b0);
        ack_bit(1'b1, "ignore_ff");
        check_eq("busy_ignore", {31'd0, busy}, 32'd1);
        do_stop();

        // FIFO full during data byte: dropped and NACKed, then ignored
        do_start();
        send_byte(8'h3C, 1'b0);
        ack_bit(1'b0, "addr_ack2");
        full = 1'b1;
        send_byte(8'h5A, 1'b0);
        ack_bit(1'b1, "full_nack");
        full = 1'b0;
        send_byte(8'h77, 1'b0);
        ack_bit(1'b1, "after_nack");
        check_eq("busy_after_nack", {31'd0, busy}, 32'd1);
        do_stop();
        check_eq("busy_stop_nack", {31'd0, busy}, 32'd0);

        // Matching read address: no ACK from the receiver
        do_start();
        send_byte(8'h3D, 1'b0);
        check_eq("addr_match_read", {31'd0, addr_match}, 32'd1);
        check_eq("rw_mode_read",    {31'd0, rw_mode},    32'd1);
        ack_bit(1'b1, "read_noack");
        do_stop();

        // Repeated START after three data bits
        do_start();
        send_byte(8'h3C, 1'b0);
        ack_bit(1'b0, "addr_ack3");
        send_bit(1'b1, 1'b0, 8'h00);
        send_bit(1'b0, 1'b0, 8'h00);
        send_bit(1'b1, 1'b0, 8'h00);
        do_start();
        send_byte(8'h3C, 1'b0);
        ack_bit(1'b0, "rstart_addr_ack");
        send_byte(8'h11, 1'b1);
        ack_bit(1'b0, "rstart_data_ack");
        check_eq("rx_data_11", {24'd0, rx_data}, 32'h0000_0011);
        do_stop();
        check_eq("start_total", n_start, 32'd6);
        check_eq("stop_total",  n_stop,  32'd5);

        // Reset during the address ACK low
        do_start();
        send_byte(8'h3C, 1'b0);
        check_eq("pre_rst_ack", {31'd0, sda_out}, 32'd0);
        sda_m = 1'b1;
        repeat (2) @(negedge clk);
        scl = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_eq("rst_async_sda", {31'd0, sda_out}, 32'd1);
        @(negedge clk);
        scl = 1'b0;
        @(negedge clk);
        scl = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

        check_eq("sb_empty",    exp_q.size(), 32'd0);
        check_eq("valid_count", n_valid,      32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
